adc_src: RTL and testbench
==========================

ADC_SRC -- requirements
Module: adc_src

Interface
REQ-001: Parameter CONV_CYCLES, default 4, conversion latency in clk cycles; legal range 1..255.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: reset  input  1  synchronous, active-high reset.
REQ-004: req  input  1  sample request from the transient streaming controller; level-sensitive, high = keep converting.
REQ-005: rdy  output  1  registered one-cycle pulse; dat is valid in the same cycle.
REQ-006: dat  output  8  registered sample value, held stable until the next rdy pulse.
REQ-007: ld_en  input  1  sample-table write strobe.
REQ-008: ld_addr  input  4  sample-table write address.
REQ-009: ld_data  input  8  sample-table write data.
REQ-010: busy  output  1  high while state is CONVERT or PRESENT.
REQ-011: smp_idx  output  4  table index of the next sample to be presented.

Function
REQ-012: The block SHALL hold a 16x8 sample table plus FSM states IDLE, CONVERT and PRESENT.
REQ-013: IDLE: req=1 at an edge -> CONVERT, with an 8-bit down-counter loaded to CONV_CYCLES-1; req=0 -> stay in IDLE.
REQ-014: CONVERT: each edge with req=1 and count>0 decrements the count; an edge with req=1 and count=0 -> PRESENT.
REQ-015: Entry to PRESENT SHALL register dat <= table[smp_idx], set rdy=1 and set smp_idx <= smp_idx+1 (mod 16, 15 wraps to 0).
REQ-016: rdy SHALL be high for exactly one cycle per sample; CONVERT is never skipped, so rdy is never high on two consecutive cycles.
REQ-017: PRESENT, next edge: req=1 -> CONVERT (count reloaded to CONV_CYCLES-1); req=0 -> IDLE.
REQ-018: Latency: req sampled high in IDLE at edge t0 -> rdy high in the cycle after edge t0+CONV_CYCLES; with req held high the sample period SHALL be CONV_CYCLES+1 cycles.
REQ-019: req=0 at any edge in CONVERT SHALL abort the conversion -> IDLE; no rdy, and dat and smp_idx are unchanged.
REQ-020: ld_en=1 SHALL write ld_data to table[ld_addr] at the edge, in any state.
REQ-021: Simultaneous write and present on the same address SHALL present the old value; the new value is visible from the next read.
REQ-022: dat SHALL change only on entry to PRESENT or on reset.
REQ-023: busy SHALL be combinationally decoded from the state register.

Reset
REQ-024: reset=1 at an edge SHALL force: state IDLE, rdy=0, dat=8'h00, smp_idx=0, count=0, all table entries 8'h00, busy=0.
REQ-025: Reset SHALL take priority over req and ld_en at the same edge.
REQ-026: Reset during CONVERT or PRESENT SHALL abort immediately, with no rdy pulse after that edge.

Structure
REQ-027: State encodings (IDLE=2'd0, CONVERT=2'd1, PRESENT=2'd2) and the table depth constant (16) SHALL live in the shared project definitions include file, alongside the tsc constants.
REQ-028: The sample table SHALL be a separate sub-module, sample_ram (16x8, synchronous write, asynchronous read, synchronous clear); the FSM and counter stay in adc_src.
REQ-029: Total RTL SHALL be 120-400 lines, with no latches and no combinational path from req to rdy or dat.

Verification
REQ-030: Reset, load table[0..3]=00,0A,99,9B, hold req=1, CONV_CYCLES=4 -> rdy pulses every 5 cycles, first 5 cycles after req is sampled; dat sequence 00,0A,99,9B.
REQ-031: Load all 16 entries with table[15]=8'h8C, table[0]=8'h00, stream 17 samples -> 16th dat=8C, 17th dat=00, smp_idx wraps to 0 then reads 1.
REQ-032: Drop req to 0 two cycles into CONVERT -> no rdy pulse, dat and smp_idx unchanged, state returns to IDLE; re-raise req -> the next sample is the same index.
REQ-033: Write table[2]=8'hD5 on the same edge that presents index 2 (old value 8'h99) -> dat=99; the next pass through index 2 gives dat=D5.
REQ-034: Assert reset for one cycle mid-CONVERT, with req held high throughout -> the following cycle shows rdy=0, dat=00, smp_idx=0, busy=0, table all zero; conversion restarts and the first dat=00.
REQ-035: CONV_CYCLES=1 with req held high -> rdy asserted every 2nd cycle, never on two consecutive cycles.

Source files
------------

// File: rtl/adc_src_pkg.sv
// Shared definitions for the ADC sample source: FSM state encodings,
// sample-table geometry and the table index helper.
package adc_src_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_PRESENT = 2'd2
    } adc_state_e;

    localparam int TBL_DEPTH = 16;
    localparam int TBL_AW    = 4;
    localparam int DAT_W     = 8;
    localparam int CNT_W     = 8;

    // Table index advance; the 4-bit add wraps 15 back to 0.
    function automatic logic [TBL_AW-1:0] next_idx(input logic [TBL_AW-1:0] idx);
        return idx + 4'd1;
    endfunction

endpackage

// File: rtl/adc_src_ram.sv
// 16x8 sample table: synchronous write, asynchronous read, synchronous clear.
// A read of an address written on the same edge returns the old contents.
module sample_ram
    import adc_src_pkg::*;
(
    input  logic              clk,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [TBL_AW-1:0] waddr_i,
    input  logic [DAT_W-1:0]  wdata_i,
    input  logic [TBL_AW-1:0] raddr_i,
    output logic [DAT_W-1:0]  rdata_o
);

    logic [DAT_W-1:0] mem_q [TBL_DEPTH];

    // Table storage: clear wins over a concurrent write.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end else begin
            mem_q <= mem_q;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/adc_src.sv
// ADC sample source: paces conversions with a down-counter and presents one
// table entry per completed conversion as a registered rdy/dat pair.
module adc_src
    import adc_src_pkg::*;
#(
    parameter int unsigned CONV_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              ld_en,
    input  logic [TBL_AW-1:0] ld_addr,
    input  logic [DAT_W-1:0]  ld_data,
    output logic              rdy,
    output logic [DAT_W-1:0]  dat,
    output logic              busy,
    output logic [TBL_AW-1:0] smp_idx
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 32'd1);

    adc_state_e        state_q;
    logic              rdy_q;
    logic [DAT_W-1:0]  dat_q;
    logic [TBL_AW-1:0] smp_idx_q;
    logic [TBL_AW-1:0] smp_idx_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DAT_W-1:0]  rd_data_s;

    sample_ram u_ram (
        .clk     (clk),
        .clr_i   (reset),
        .we_i    (ld_en),
        .waddr_i (ld_addr),
        .wdata_i (ld_data),
        .raddr_i (smp_idx_q),
        .rdata_o (rd_data_s)
    );

    assign smp_idx_d = next_idx(smp_idx_q);

    // Conversion FSM; rdy, dat and smp_idx only move on entry to PRESENT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rdy_q     <= 1'b0;
            dat_q     <= 8'h00;
            smp_idx_q <= 4'd0;
            cnt_q     <= 8'd0;
        end else begin
            rdy_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_q <= ST_CONVERT;
                        cnt_q   <= CNT_LOAD;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CONVERT: begin
                    if (!req) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        // Table read is asynchronous, so a same-edge write is not yet visible.
                        state_q   <= ST_PRESENT;
                        rdy_q     <= 1'b1;
                        dat_q     <= rd_data_s;
                        smp_idx_q <= smp_idx_d;
                    end
                end
                ST_PRESENT: begin
                    if (req) begin
                        state_q <= ST_CONVERT;
                        cnt_q   <= CNT_LOAD;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = (state_q == ST_CONVERT) || (state_q == ST_PRESENT);
    assign rdy     = rdy_q;
    assign dat     = dat_q;
    assign smp_idx = smp_idx_q;

endmodule

// File: tb/tb_adc_src.sv
// Directed bench for adc_src: one instance at the default conversion latency
// and one at the minimum latency, with hand-computed expected samples.
module tb_adc_src;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic       req1;
    logic       ld_en;
    logic [3:0] ld_addr;
    logic [7:0] ld_data;
    logic       rdy,  rdy1;
    logic [7:0] dat,  dat1;
    logic       busy, busy1;
    logic [3:0] smp_idx, smp_idx1;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_tbl [16];

    adc_src #(.CONV_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .req(req), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .rdy(rdy), .dat(dat), .busy(busy), .smp_idx(smp_idx)
    );

    adc_src #(.CONV_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .rdy(rdy1), .dat(dat1), .busy(busy1), .smp_idx(smp_idx1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    // Waits for the next rdy on the CONV_CYCLES=4 instance and checks latency and payload.
    task automatic expect_sample(input string tag, input int exp_lat,
                                 input logic [7:0] exp_dat, input logic [3:0] exp_idx);
        int n;
        logic [7:0] held;
        logic moved;
        n = 0;
        held = dat;
        moved = 1'b0;
        do begin
            tick();
            n++;
            if (!rdy && dat !== held) moved = 1'b1;
        end while (rdy !== 1'b1 && n < 32);
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_dat"}, 32'(dat), 32'(exp_dat));
        chk({tag, "_idx"}, 32'(smp_idx), 32'(exp_idx));
        chk({tag, "_hold"}, 32'(moved), 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        req     = 1'b0;
        req1    = 1'b0;
        ld_en   = 1'b0;
        ld_addr = 4'd0;
        ld_data = 8'h00;
        exp_tbl[0] = 8'h00;
        exp_tbl[1] = 8'h0A;
        exp_tbl[2] = 8'h99;
        exp_tbl[3] = 8'h9B;
        for (int i = 4; i < 15; i++) exp_tbl[i] = 8'(i * 17);
        exp_tbl[15] = 8'h8C;

        tick();
        tick();
        chk("rst_rdy",  32'(rdy),     32'd0);
        chk("rst_dat",  32'(dat),     32'h00);
        chk("rst_idx",  32'(smp_idx), 32'd0);
        chk("rst_busy", 32'(busy),    32'd0);
        chk("rst_busy1", 32'(busy1),  32'd0);

        reset = 1'b0;
        for (int i = 0; i < 16; i++) wr(4'(i), exp_tbl[i]);
        chk("idle_after_load", 32'(busy), 32'd0);

        // Continuous streaming: first sample 5 cycles after req is sampled, then every 5.
        req = 1'b1;
        for (int k = 0; k < 18; k++) begin
            expect_sample($sformatf("stream%0d", k), 5, exp_tbl[k % 16], 4'((k + 1) % 16));
        end

        // Abort two cycles into CONVERT: idx 2 stays pending, dat keeps 0A.
        tick();
        tick();
        chk("abort_busy_pre", 32'(busy), 32'd1);
        req = 1'b0;
        tick();
        chk("abort_rdy",  32'(rdy),     32'd0);
        chk("abort_busy", 32'(busy),    32'd0);
        chk("abort_dat",  32'(dat),     32'h0A);
        chk("abort_idx",  32'(smp_idx), 32'd2);
        tick();
        chk("abort_idle_rdy", 32'(rdy), 32'd0);

        // Re-raise req and overwrite table[2] on the very edge that presents it.
        req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("coll_wait_rdy", 32'(rdy), 32'd0);
        end
        ld_en   = 1'b1;
        ld_addr = 4'd2;
        ld_data = 8'hD5;
        tick();
        ld_en = 1'b0;
        chk("coll_rdy", 32'(rdy),     32'd1);
        chk("coll_dat", 32'(dat),     32'h99);
        chk("coll_idx", 32'(smp_idx), 32'd3);
        exp_tbl[2] = 8'hD5;
        for (int k = 3; k < 19; k++) begin
            expect_sample($sformatf("pass2_%0d", k % 16), 5, exp_tbl[k % 16], 4'((k + 1) % 16));
        end

        // Reset mid-CONVERT with req high; a concurrent table write must lose to reset.
        tick();
        tick();
        reset   = 1'b1;
        ld_en   = 1'b1;
        ld_addr = 4'd1;
        ld_data = 8'h77;
        tick();
        reset = 1'b0;
        ld_en = 1'b0;
        chk("mid_rst_rdy",  32'(rdy),     32'd0);
        chk("mid_rst_dat",  32'(dat),     32'h00);
        chk("mid_rst_idx",  32'(smp_idx), 32'd0);
        chk("mid_rst_busy", 32'(busy),    32'd0);
        expect_sample("post_rst0", 5, 8'h00, 4'd1);
        expect_sample("post_rst1", 5, 8'h00, 4'd2);
        req = 1'b0;
        tick();
        chk("post_rst_idle", 32'(busy), 32'd0);

        // Minimum latency instance: rdy every second cycle.
        wr(4'd0, 8'h5A);
        wr(4'd1, 8'hA5);
        req1 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("c1_rdy%0d", k), 32'(rdy1), (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k % 2 == 0) begin
                chk($sformatf("c1_dat%0d", k), 32'(dat1),
                    (k == 2) ? 32'h5A : ((k == 4) ? 32'hA5 : 32'h00));
                chk($sformatf("c1_idx%0d", k), 32'(smp_idx1), 32'(k / 2));
            end
        end
        req1 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
